// File: rtl/multimem_write_arbiter.sv
// Round-robin write arbiter for two requesters in front of a multimem write port,
// with a whole-memory fill sweep that takes priority over both requesters.
module multimem_write_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_clk_enable,
  output logic                  ram_wr
);

  typedef enum logic {SERVE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  last_q, last_d;      // 1: requester 1 was granted most recently
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;        // fill address currently on the port
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic                  grant0, grant1;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;

    case (state_q)
      SERVE: begin
        if (fill_start) begin
          // First fill write (address 0) is presented on the first FILL cycle.
          state_d    = FILL;
          fill_val_d = fill_value;
          cnt_d      = '0;
          addr_d     = '0;
          data_d     = fill_value;
          wr_d       = 1'b1;
        end else begin
          grant0 = req0_valid & (~req1_valid | last_q);
          grant1 = req1_valid & (~req0_valid | ~last_q);
          if (grant0) begin
            addr_d = req0_addr;
            data_d = req0_data;
            wr_d   = 1'b1;
            last_d = 1'b0;
          end else if (grant1) begin
            addr_d = req1_addr;
            data_d = req1_data;
            wr_d   = 1'b1;
            last_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (cnt_q == '1) begin
          state_d = SERVE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + ADDR_ONE;
          addr_d = cnt_q + ADDR_ONE;
          data_d = fill_val_q;
          wr_d   = 1'b1;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SERVE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      fill_val_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
    end
  end

  assign req0_ready     = grant0;
  assign req1_ready     = grant1;
  assign fill_busy      = (state_q == FILL);
  assign fill_done      = done_q;
  assign ram_address    = addr_q;
  assign ram_data_in    = data_q;
  assign ram_clk_enable = wr_q;
  assign ram_wr         = wr_q;

endmodule

// File: tb/tb_multimem_write_arbiter.sv
// Scoreboard bench for multimem_write_arbiter: the driver's reference model queues
// expected grants and writes per cycle, and a negedge monitor compares the DUT.
module tb_multimem_write_arbiter;

  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_value = '0;
  logic          fill_busy, fill_done;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_clk_enable, ram_wr;

  multimem_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_clk_enable(ram_clk_enable), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int cyc;
    bit r0;
    bit r1;
    bit busy;
    bit done;
  } ctl_t;

  wr_t  wq[$];
  ctl_t rq[$];

  // Reference model: who won last, and the cycle window of the active fill.
  int m_last     = 1;
  int fill_first = -10;
  int fill_last  = -10;
  int done_cyc   = -10;

  task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input bit fs, input logic [DW-1:0] fv,
                      output bit g0, output bit g1);
    int  c;
    bit  in_fill;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    fill_start = fs; fill_value = fv;
    c       = cyc;
    in_fill = (c >= fill_first) && (c <= fill_last);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!in_fill) begin
      if (fs) begin
        fill_first = c + 1;
        fill_last  = c + NWORDS;
        done_cyc   = c + NWORDS + 1;
        for (int k = 0; k < NWORDS; k++) wq.push_back('{c + 1 + k, AW'(k), fv});
      end else begin
        if (v0 && v1) begin
          if (m_last == 1) g0 = 1'b1;
          else             g1 = 1'b1;
        end else begin
          g0 = v0;
          g1 = v1;
        end
        if (g0) begin
          m_last = 0;
          wq.push_back('{c + 1, a0, d0});
        end
        if (g1) begin
          m_last = 1;
          wq.push_back('{c + 1, a1, d1});
        end
      end
    end
    rq.push_back('{c, g0, g1, in_fill, (c == done_cyc)});
  endtask

  task automatic idle();
    bit g0, g1;
    step(0, '0, '0, 0, '0, '0, 0, '0, g0, g1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, int'(ram_address), 0);
    check({tag, "_data"}, int'(ram_data_in), 0);
    check({tag, "_wr"}, int'(ram_wr), 0);
    check({tag, "_ce"}, int'(ram_clk_enable), 0);
    check({tag, "_busy"}, int'(fill_busy), 0);
    check({tag, "_done"}, int'(fill_done), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;
  always @(negedge clk) begin
    ctl_t r;
    wr_t  w;
    if (reset) begin
      hold_a = '0;
      hold_d = '0;
    end else begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        check("req0_ready", int'(req0_ready), int'(r.r0));
        check("req1_ready", int'(req1_ready), int'(r.r1));
        check("fill_busy", int'(fill_busy), int'(r.busy));
        check("fill_done", int'(fill_done), int'(r.done));
      end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        w = wq.pop_front();
        check("write_missed_cycle", cyc, w.cyc);
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w = wq.pop_front();
        check("ram_wr", int'(ram_wr), 1);
        check("ram_clk_enable", int'(ram_clk_enable), 1);
        check("ram_address", int'(ram_address), int'(w.a));
        check("ram_data_in", int'(ram_data_in), int'(w.d));
        hold_a = w.a;
        hold_d = w.d;
      end else begin
        check("idle_ram_wr", int'(ram_wr), 0);
        check("idle_ram_clk_enable", int'(ram_clk_enable), 0);
        check("idle_hold_address", int'(ram_address), int'(hold_a));
        check("idle_hold_data", int'(ram_data_in), int'(hold_d));
      end
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    finish_run();
  end

  initial begin
    bit            g0, g1, pend0, pend1, fs, got;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    int            n;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Contention from a fresh pointer: expect grants 0,1,0,1.
    for (int i = 0; i < 4; i++) step(1, 12'h000, 8'h42, 1, 12'h001, 8'h43, 0, '0, g0, g1);
    idle();

    // Single write at the top address.
    step(1, 12'hFFF, 8'h41, 0, '0, '0, 0, '0, g0, g1);
    idle();
    idle();

    // Randomised traffic; requesters hold their request until accepted.
    pend0 = 0; pend1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && ($urandom_range(2) == 0)) begin
        pend0 = 1; pa0 = AW'($urandom_range(NWORDS - 1)); pd0 = DW'($urandom_range(255));
      end
      if (!pend1 && ($urandom_range(2) == 0)) begin
        pend1 = 1; pa1 = AW'($urandom_range(NWORDS - 1)); pd1 = DW'($urandom_range(255));
      end
      fs = ($urandom_range(99) == 0);
      step(pend0, pa0, pd0, pend1, pa1, pd1, fs, DW'($urandom_range(255)), g0, g1);
      if (g0) pend0 = 0;
      if (g1) pend1 = 0;
    end
    n = 0;
    while (cyc <= done_cyc + 1 && n < 5000) begin
      idle();
      n++;
    end
    idle();

    // Fill colliding with a requester-1 write; it must land on the done cycle.
    step(0, '0, '0, 1, 12'h123, 8'h5A, 1, 8'h20, g0, g1);
    got = 0;
    n = 0;
    while (!got && n < 5000) begin
      step(0, '0, '0, 1, 12'h123, 8'h5A, 0, '0, g0, g1);
      got = g1;
      n++;
    end
    idle();
    idle();

    // Reset in the middle of a fill, at address 0x800.
    step(0, '0, '0, 0, '0, '0, 1, 8'hA5, g0, g1);
    repeat (12'h800) idle();
    @(posedge clk);
    #1;
    check("midfill_addr", int'(ram_address), 'h800);
    check("midfill_wr", int'(ram_wr), 1);
    check("midfill_data", int'(ram_data_in), 'hA5);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    wq.delete();
    rq.delete();
    m_last     = 1;
    fill_first = -10;
    fill_last  = -10;
    done_cyc   = -10;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) idle();

    // Pointer is back at requester 1, so requester 0 wins this tie.
    step(1, 12'h010, 8'h11, 1, 12'h020, 8'h22, 0, '0, g0, g1);
    step(0, '0, '0, 1, 12'h020, 8'h22, 0, '0, g0, g1);
    idle();
    step(1, 12'hFFF, 8'h41, 0, '0, '0, 0, '0, g0, g1);
    idle();
    idle();

    check("writes_outstanding", wq.size(), 0);
    finish_run();
  end

endmodule
